seg_shift_ctrl: RTL



---
 rtl/seg_shift_ctrl_pkg.sv | 26 ++
 rtl/seg_shift_ctrl_tick_gen.sv | 36 +++
 rtl/seg_shift_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/seg_shift_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_defs (package)
//  Description : Shared constants, state encodings and helpers for the
//                74HC595 segment-chain serialiser.
//  Revision    : 1.0  initial release
// ============================================================================
package seg_defs;

    localparam int c_SEG_BITS        = 64;
    localparam int c_HALF_PER_DEF    = 4;
    localparam int c_REFRESH_PER_DEF = 65536;

    localparam int                   c_STATE_W   = 2;
    localparam logic [c_STATE_W-1:0] c_ST_IDLE   = 2'd0;
    localparam logic [c_STATE_W-1:0] c_ST_LOAD   = 2'd1;
    localparam logic [c_STATE_W-1:0] c_ST_SHIFT  = 2'd2;
    localparam logic [c_STATE_W-1:0] c_ST_LATCH  = 2'd3;

    // MSB leaves first, so the frame register always shifts towards bit 63.
    function automatic logic [c_SEG_BITS-1:0] seg_shl1(input logic [c_SEG_BITS-1:0] v);
        return {v[c_SEG_BITS-2:0], 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_shift_ctrl_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : seg_tick_gen
//  Description : Half-period counter; emits a 1-clk tick on the last clk of
//                every HALF_PER-clk half period.
//  Revision    : 1.0  initial release
// ============================================================================
module seg_tick_gen #(
    parameter int HALF_PER = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int                 c_CNT_W = $clog2(HALF_PER + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(HALF_PER - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               w_last;

    assign w_last = (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (rst || clear || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = w_last && !clear;

endmodule
`default_nettype wire

// File: rtl/seg_shift_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg_shift_ctrl
//  Description : Serialises a 64-bit segment image MSB-first into a daisy
//                chain of 74HC595s, then pulses the storage latch.
//                Optional macro SEG_AUTO_REFRESH_EN adds a periodic request.
//  Revision    : 1.0  initial release
// ============================================================================
module seg_shift_ctrl
    import seg_defs::*;
#(
    parameter int HALF_PER    = c_HALF_PER_DEF,
    parameter int SEG_BITS    = c_SEG_BITS,
    parameter int REFRESH_PER = c_REFRESH_PER_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SEG_BITS-1:0] seg_txt,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                seg_clk,
    output logic                seg_sout,
    output logic                seg_lat,
    output logic                seg_clrn
);

    localparam int c_BIT_W = $clog2(SEG_BITS);

    if (HALF_PER < 1 || HALF_PER > 255 || SEG_BITS != c_SEG_BITS || REFRESH_PER < 2) begin : g_bad_param
        $error("seg_shift_ctrl: illegal parameter value");
    end

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_nxt;
    logic                 r_phase;
    logic                 w_phase_nxt;
    logic [SEG_BITS-1:0]  r_shreg;
    logic [c_BIT_W-1:0]   r_bit_cnt;
    logic                 r_pending;
    logic                 r_done;
    logic                 w_done_nxt;
    logic                 r_clrn;
    logic                 w_take;
    logic                 w_step;
    logic                 w_req;
    logic                 w_auto_req;
    logic                 w_tick;
    logic                 w_tick_clear;

`ifdef SEG_AUTO_REFRESH_EN
    localparam int                 c_REF_W    = $clog2(REFRESH_PER);
    localparam logic [c_REF_W-1:0] c_REF_LAST = c_REF_W'(REFRESH_PER - 1);

    logic [c_REF_W-1:0] r_ref_cnt;

    always_ff @(posedge clk) begin
        if (rst || w_auto_req) begin
            r_ref_cnt <= '0;
        end else begin
            r_ref_cnt <= r_ref_cnt + 1'b1;
        end
    end

    assign w_auto_req = (r_ref_cnt == c_REF_LAST);
`else
    assign w_auto_req = 1'b0;
`endif

    assign w_req = start || w_auto_req;

    // Counter is held at zero outside the serial phases so SHIFT starts on a clean half.
    assign w_tick_clear = (r_state == c_ST_IDLE) || (r_state == c_ST_LOAD);

    seg_tick_gen #(
        .HALF_PER (HALF_PER)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (w_tick_clear),
        .tick  (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_done_nxt  = 1'b0;
        w_take      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_phase_nxt = 1'b0;
                if (w_req || r_pending) begin
                    w_state_nxt = c_ST_LOAD;
                    w_take      = 1'b1;
                end
            end
            c_ST_LOAD: begin
                w_state_nxt = c_ST_SHIFT;
                w_phase_nxt = 1'b0;
            end
            c_ST_SHIFT: begin
                if (w_tick) begin
                    w_phase_nxt = !r_phase;
                    if (r_phase) begin
                        w_step = 1'b1;
                        if (r_bit_cnt == '0) begin
                            w_state_nxt = c_ST_LATCH;
                        end
                    end
                end
            end
            c_ST_LATCH: begin
                if (w_tick) begin
                    w_phase_nxt = !r_phase;
                    if (r_phase) begin
                        w_state_nxt = c_ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_phase_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_phase   <= 1'b0;
            r_done    <= 1'b0;
            r_clrn    <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_done  <= w_done_nxt;
            r_clrn  <= 1'b1;
            // One-deep request memory; any number of requests while busy merge.
            if (w_take) begin
                r_pending <= 1'b0;
            end else if (w_req && busy) begin
                r_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else if (r_state == c_ST_LOAD) begin
            r_shreg   <= seg_txt;
            r_bit_cnt <= '1;
        end else if (w_step) begin
            r_shreg   <= seg_shl1(r_shreg);
            r_bit_cnt <= r_bit_cnt - 1'b1;
        end
    end

    assign busy     = (r_state != c_ST_IDLE);
    assign done     = r_done;
    assign seg_clrn = r_clrn;
    assign seg_clk  = (r_state == c_ST_SHIFT) && r_phase;
    assign seg_lat  = (r_state == c_ST_LATCH) && r_phase;

    always_comb begin
        seg_sout = 1'b0;
        if (r_state == c_ST_LOAD) begin
            seg_sout = seg_txt[SEG_BITS-1];
        end else if (r_state == c_ST_SHIFT) begin
            seg_sout = r_shreg[SEG_BITS-1];
        end
    end

endmodule
`default_nettype wire
